// File: rtl/hv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hv_pkg                                                          |
// | Purpose  : Shared types and constants for the hypervector bundler: the     |
// |            FSM state type and the saturation limits of the signed          |
// |            per-dimension counters.                                         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package hv_pkg;

  localparam int HV_DIMENSION_DEF   = 512;
  localparam int COUNTER_WIDTH_DEF  = 8;
  localparam int ITEM_CNT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_BIN   = 2'd1,
    ST_OUT   = 2'd2
  } bundler_state_t;

  // Most positive value of a signed two's-complement counter of this width.
  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Most negative value of a signed two's-complement counter of this width.
  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

  localparam int SAT_MAX_DEF = sat_max(COUNTER_WIDTH_DEF);
  localparam int SAT_MIN_DEF = sat_min(COUNTER_WIDTH_DEF);

endpackage
`default_nettype wire

// File: rtl/hv_bundler_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hv_bundler_unit_if                                              |
// | Purpose  : Groups the bundler's data/handshake/control signals.            |
// |            slave  : view of the bundler itself                             |
// |            master : view of the surrounding logic (ALU side + consumer)    |
// | Ports    : hv_i/hv_valid_i/hv_ready_o  input vector stream                 |
// |            clr_i, bin_req_i            control                             |
// |            hv_o/hv_valid_o/hv_ready_i  bundled vector stream               |
// |            item_cnt_o                  accepted-vector count               |
// |            sat_o                       sticky saturation flag (only with   |
// |                                        HV_BUNDLER_SAT_FLAG_EN)             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface hv_bundler_unit_if #(
  parameter int HV_DIMENSION   = 512,
  parameter int ITEM_CNT_WIDTH = 16
);

  logic [HV_DIMENSION-1:0]   hv_i;
  logic                      hv_valid_i;
  logic                      hv_ready_o;
  logic                      clr_i;
  logic                      bin_req_i;
  logic [HV_DIMENSION-1:0]   hv_o;
  logic                      hv_valid_o;
  logic                      hv_ready_i;
  logic [ITEM_CNT_WIDTH-1:0] item_cnt_o;
`ifdef HV_BUNDLER_SAT_FLAG_EN
  logic                      sat_o;
`endif

  modport slave (
    input  hv_i, hv_valid_i, clr_i, bin_req_i, hv_ready_i,
    output hv_ready_o, hv_o, hv_valid_o, item_cnt_o
`ifdef HV_BUNDLER_SAT_FLAG_EN
    , output sat_o
`endif
  );

  modport master (
    output hv_i, hv_valid_i, clr_i, bin_req_i, hv_ready_i,
    input  hv_ready_o, hv_o, hv_valid_o, item_cnt_o
`ifdef HV_BUNDLER_SAT_FLAG_EN
    , input sat_o
`endif
  );

endinterface
`default_nettype wire

// File: rtl/hv_bundler_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hv_bundler_cell                                                 |
// | Purpose  : One signed saturating up/down counter for a single hypervector  |
// |            dimension, with synchronous clear and a binarized output.       |
// | Ports    : clk, rst_n  clock / asynchronous active-low reset              |
// |            clr         synchronous clear (wins over en)                    |
// |            en          count this cycle                                    |
// |            bit_in      1 = count up, 0 = count down                        |
// |            pos         counter is strictly positive                        |
// |            ovf         an enabled step was blocked by saturation           |
// |                        (present only with HV_BUNDLER_SAT_FLAG_EN)          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module hv_bundler_cell
  import hv_pkg::*;
#(
  parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clr,
  input  wire logic en,
  input  wire logic bit_in,
  output logic      pos
`ifdef HV_BUNDLER_SAT_FLAG_EN
  , output logic    ovf
`endif
);

  localparam logic signed [COUNTER_WIDTH-1:0] c_cnt_max = COUNTER_WIDTH'(sat_max(COUNTER_WIDTH));
  localparam logic signed [COUNTER_WIDTH-1:0] c_cnt_min = COUNTER_WIDTH'(sat_min(COUNTER_WIDTH));
  localparam logic signed [COUNTER_WIDTH-1:0] c_one     = COUNTER_WIDTH'(1);

  logic signed [COUNTER_WIDTH-1:0] r_cnt;
  logic                            w_at_limit;

  // The counter is pinned when it already sits at the limit in the
  // direction it is being asked to move.
  assign w_at_limit = bit_in ? (r_cnt == c_cnt_max) : (r_cnt == c_cnt_min);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !w_at_limit) begin
      r_cnt <= bit_in ? (r_cnt + c_one) : (r_cnt - c_one);
    end
  end

  // Strictly positive: sign clear and not zero, so a tie binarizes to 0.
  assign pos = !r_cnt[COUNTER_WIDTH-1] && (|r_cnt);

`ifdef HV_BUNDLER_SAT_FLAG_EN
  assign ovf = en && w_at_limit;
`endif

endmodule
`default_nettype wire

// File: rtl/hv_bundler_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hv_bundler_unit                                                 |
// | Purpose  : Bundles a stream of binary hypervectors into per-dimension      |
// |            saturating counters and, on request, binarizes them into one    |
// |            hypervector delivered over a valid/ready handshake.             |
// | Ports    : clk_i   clock                                                   |
// |            rst_ni  asynchronous active-low reset                           |
// |            bus     hv_bundler_unit_if.slave (vector in/out, clr_i,         |
// |                    bin_req_i, item_cnt_o, optional sat_o)                  |
// | Options  : HV_BUNDLER_SAT_FLAG_EN adds the sticky saturation flag sat_o.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module hv_bundler_unit
  import hv_pkg::*;
#(
  parameter int HV_DIMENSION   = HV_DIMENSION_DEF,
  parameter int COUNTER_WIDTH  = COUNTER_WIDTH_DEF,
  parameter int ITEM_CNT_WIDTH = ITEM_CNT_WIDTH_DEF
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  hv_bundler_unit_if.slave  bus
);

  localparam logic [ITEM_CNT_WIDTH-1:0] c_item_one = ITEM_CNT_WIDTH'(1);

  bundler_state_t            r_state;
  bundler_state_t            w_state_next;
  logic                      w_hv_ready;
  logic                      w_hv_valid;
  logic                      w_accept;
  logic [HV_DIMENSION-1:0]   w_pos;
  logic [HV_DIMENSION-1:0]   r_hv_o;
  logic [ITEM_CNT_WIDTH-1:0] r_item_cnt;

  // A vector offered together with clr_i is discarded even though ready is high.
  assign w_accept = w_hv_ready && bus.hv_valid_i && !bus.clr_i;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hv_ready   = 1'b0;
    w_hv_valid   = 1'b0;
    unique case (r_state)
      ST_ACCUM: begin
        w_hv_ready = 1'b1;
        if (bus.bin_req_i) w_state_next = ST_BIN;
      end
      ST_BIN: begin
        w_state_next = ST_OUT;
      end
      ST_OUT: begin
        w_hv_valid = 1'b1;
        if (bus.hv_ready_i) w_state_next = ST_ACCUM;
      end
      default: begin
        w_state_next = ST_ACCUM;
      end
    endcase
    if (bus.clr_i) w_state_next = ST_ACCUM;
  end

  // ------------------------------------------------------ counter array
`ifdef HV_BUNDLER_SAT_FLAG_EN
  logic [HV_DIMENSION-1:0] w_ovf;
  logic                    r_sat;
`endif

  for (genvar k = 0; k < HV_DIMENSION; k++) begin : g_cell
    hv_bundler_cell #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_cell (
      .clk    (clk_i),
      .rst_n  (rst_ni),
      .clr    (bus.clr_i),
      .en     (w_accept),
      .bit_in (bus.hv_i[k]),
      .pos    (w_pos[k])
`ifdef HV_BUNDLER_SAT_FLAG_EN
      , .ovf  (w_ovf[k])
`endif
    );
  end

`ifdef HV_BUNDLER_SAT_FLAG_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sat <= 1'b0;
    end else if (bus.clr_i) begin
      r_sat <= 1'b0;
    end else if (|w_ovf) begin
      r_sat <= 1'b1;
    end
  end
  assign bus.sat_o = r_sat;
`endif

  // ------------------------------------------------------- item counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_item_cnt <= '0;
    end else if (bus.clr_i) begin
      r_item_cnt <= '0;
    end else if (w_accept && !(&r_item_cnt)) begin
      r_item_cnt <= r_item_cnt + c_item_one;
    end
  end

  // ------------------------------------------------ binarized result
  // Captured only in the single ST_BIN cycle; a clear keeps the old value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hv_o <= '0;
    end else if (r_state == ST_BIN && !bus.clr_i) begin
      r_hv_o <= w_pos;
    end
  end

  assign bus.hv_ready_o = w_hv_ready;
  assign bus.hv_valid_o = w_hv_valid;
  assign bus.hv_o       = r_hv_o;
  assign bus.item_cnt_o = r_item_cnt;

endmodule
`default_nettype wire

// File: doc/hv_bundler_unit.md
Name: hv_bundler_unit

Overview:
- Downstream consumer of the hypervector ALU PE output.
- Accumulates a stream of binary hypervectors into per-dimension signed saturating counters (bundling / majority superposition).
- On request, binarizes the counters into one bundled hypervector and hands it out over a valid/ready handshake.
- Sits between the encoder ALU and the associative memory / class-HV store.

Parameters:
- HVDimension, 512, hypervector width in bits; one counter per bit.
- CounterWidth, 8, signed two's-complement width of each per-bit counter.
- ItemCntWidth, 16, width of the accepted-vector counter.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- hv_i  input  HVDimension  hypervector to bundle (ALU C_o)
- hv_valid_i  input  1  hv_i valid
- hv_ready_o  output  1  unit can accept hv_i
- clr_i  input  1  synchronous clear of counters and item count
- bin_req_i  input  1  pulse: binarize current accumulation
- hv_o  output  HVDimension  binarized bundled hypervector
- hv_valid_o  output  1  hv_o valid
- hv_ready_i  input  1  downstream accepts hv_o
- item_cnt_o  output  ItemCntWidth  number of vectors accepted since last clear

Behaviour:
- Reset (async, rst_ni=0):
  - All counters are 0, item_cnt_o=0, hv_o=0, hv_valid_o=0.
  - State is ST_ACCUM, so hv_ready_o=1.
- FSM states: ST_ACCUM, ST_BIN, ST_OUT.
- ST_ACCUM:
  - hv_ready_o=1.
  - On hv_valid_i, for each bit k: counter[k] += 1 if hv_i[k]=1, else counter[k] -= 1.
  - Counters saturate at +2^(CW-1)-1 and -2^(CW-1); no wrap.
  - item_cnt_o increments, saturating at all-ones.
  - bin_req_i moves the FSM to ST_BIN. If hv_valid_i and bin_req_i are both high in the same cycle, the vector is accumulated and is included in the result.
- ST_BIN (exactly 1 cycle):
  - hv_ready_o=0.
  - Registers hv_o[k] = 1 if counter[k] > 0, else 0. A tie (counter = 0) yields 0.
  - Next state is ST_OUT.
- ST_OUT:
  - hv_ready_o=0, hv_valid_o=1.
  - hv_o is held stable until hv_ready_i.
  - On hv_valid_o & hv_ready_i: hv_valid_o drops next cycle and the FSM returns to ST_ACCUM.
  - Counters are not cleared; the accumulation continues unless clr_i is used.
- Latency: bin_req_i at cycle t gives hv_valid_o=1 at cycle t+2.
- clr_i (any state, highest priority):
  - Next cycle: counters=0, item_cnt_o=0, hv_valid_o=0, state=ST_ACCUM.
  - hv_o keeps its last value.
  - A vector presented in the same cycle as clr_i is dropped: hv_ready_o stays 1, but the handshake is discarded.
- bin_req_i outside ST_ACCUM is ignored.
- hv_valid_i while hv_ready_o=0 is ignored; the upstream must hold the vector.
- Reset mid-output: hv_valid_o drops immediately (async) and all state clears.

Optional Feature:
- Macro: HV_BUNDLER_SAT_FLAG_EN.
- Defined:
  - Adds output port sat_o (1 bit).
  - sat_o is sticky; it sets in the cycle after any counter would have exceeded its range.
  - Cleared by reset or clr_i.
- Undefined:
  - Port and flag logic are absent.
  - Counters still saturate identically.

Decomposition:
- Shared package hv_pkg holds:
  - the FSM state typedef (bundler_state_t: ST_ACCUM, ST_BIN, ST_OUT);
  - the counter saturation constants derived from CounterWidth.
- Sub-module hv_bundler_cell:
  - one signed saturating up/down counter with clear, sign-bit binarize output and overflow indication;
  - instantiated HVDimension times by generate.
- Top level holds the FSM, item counter, hv_o register and handshake.

Test Plan (HVDimension=8, CounterWidth=4, range -8..7):
- Reset asserted mid-run -> hv_valid_o=0, hv_o=8'h00, item_cnt_o=0, hv_ready_o=1 immediately and after release.
- Accept 8'hF0, 8'hF0, 8'h0F, then bin_req_i at cycle t -> hv_valid_o=1 at t+2, hv_o=8'hF0, item_cnt_o=3.
- Accept 8'hAA then 8'h55 (all counters 0), binarize -> hv_o=8'h00; 8'hAA with bin_req_i in the same cycle -> hv_o=8'hAA.
- Accept 8'hFF x10 then 8'h00 x1 -> counters 6, hv_o=8'hFF; with HV_BUNDLER_SAT_FLAG_EN, sat_o=1 from the 9th accept.
- Hold hv_ready_i=0 for 5 cycles in ST_OUT while driving hv_valid_i=1 -> hv_o stable, hv_ready_o=0, item_cnt_o unchanged; hv_ready_i=1 -> return to ST_ACCUM next cycle.
- clr_i in ST_OUT with hv_valid_i=1 -> hv_valid_o=0 and item_cnt_o=0 next cycle, vector dropped; following binarize of 8'h3C alone -> hv_o=8'h3C, item_cnt_o=1.
